hex_update_ctrl: RTL and testbench

Sequencer that owns the bank of eight 7-segment output PIOs (one 7-bit register each, register address 0) in the vending-machine display path. Two requesters hand it a 4-digit hex/BCD value:
- Requester 0: price digits, HEX0..HEX3.
- Requester 1: paid/change digits, HEX4..HEX7.

It arbitrates round-robin, decodes each nibble to an active-low segment pattern and issues one bus write per digit to the matching PIO.

---
 rtl/hex_update_if.sv | 26 ++
 rtl/hex_update_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hex_update_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hex_update_if.sv
// Requester/PIO-bus bundle for hex_update_ctrl: two 4-digit update requesters
// on one side, the shared 7-segment PIO write bus on the other.
interface hex_update_if #(
  parameter int DIGITS = 4
);
  logic [1:0]          req;
  logic [4*DIGITS-1:0] value0;
  logic [4*DIGITS-1:0] value1;
  logic [1:0]          ack;
  logic [1:0]          done;
  logic                busy;
  logic [2*DIGITS-1:0] pio_cs;
  logic                pio_write_n;
  logic [1:0]          pio_address;
  logic [6:0]          pio_writedata;

  modport master (
    output req, value0, value1,
    input  ack, done, busy, pio_cs, pio_write_n, pio_address, pio_writedata
  );

  modport slave (
    input  req, value0, value1,
    output ack, done, busy, pio_cs, pio_write_n, pio_address, pio_writedata
  );
endinterface

// File: rtl/hex_update_ctrl.sv
// Round-robin sequencer writing two 4-digit values to eight 7-segment PIOs.
// Optional leading-zero blanking is enabled by defining HEX_LZB_EN.
module hex_update_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  hex_update_if.slave  bus
);

  localparam int NPIO  = 2 * DIGITS;
  localparam int VAL_W = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_gnt, w_gnt_nxt;
  logic             r_last, w_last_nxt;
  logic [VAL_W-1:0] r_value, w_value_nxt;
  logic [1:0]       r_ack, w_ack_nxt;
  logic [1:0]       r_done, w_done_nxt;
  logic             r_busy, w_busy_nxt;
  logic [NPIO-1:0]  r_cs, w_cs_nxt;
  logic             r_wr_n, w_wr_n_nxt;
  logic [6:0]       r_wdata, w_wdata_nxt;

  logic             w_g;
  logic [VAL_W-1:0] w_sel_value;
  logic [CNT_W-1:0] w_k;

  function automatic logic [6:0] seg(input logic [3:0] nib);
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction

  // Pattern for digit k; with blanking, a zero digit with only zeros above it goes dark.
  function automatic logic [6:0] digit_pat(input logic [VAL_W-1:0] val,
                                           input logic [CNT_W-1:0] k);
    logic [VAL_W-1:0] upper;
    upper     = val >> {k, 2'b00};
    digit_pat = seg(upper[3:0]);
`ifdef HEX_LZB_EN
    if ((k != '0) && (upper == '0)) digit_pat = 7'h7F;
`endif
  endfunction

  function automatic logic [NPIO-1:0] pio_sel(input logic g, input logic [CNT_W-1:0] k);
    int idx;
    idx     = (g ? DIGITS : 0) + int'(k);
    pio_sel = {{(NPIO-1){1'b0}}, 1'b1} << idx;
  endfunction

  // r_last holds the requester granted most recently; on a tie the other one wins.
  assign w_g         = bus.req[1] & (~bus.req[0] | ~r_last);
  assign w_sel_value = w_g ? bus.value1 : bus.value0;
  assign w_k         = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_value_nxt = r_value;
    w_ack_nxt   = 2'b00;
    w_done_nxt  = 2'b00;
    w_busy_nxt  = 1'b0;
    w_cs_nxt    = '0;
    w_wr_n_nxt  = 1'b1;
    w_wdata_nxt = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          // Digit 0 goes out in the grant cycle, so it is decoded from the live input.
          w_state_nxt = S_WRITE;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = w_g;
          w_last_nxt  = w_g;
          w_value_nxt = w_sel_value;
          w_ack_nxt   = w_g ? 2'b10 : 2'b01;
          w_busy_nxt  = 1'b1;
          w_cs_nxt    = pio_sel(w_g, '0);
          w_wr_n_nxt  = 1'b0;
          w_wdata_nxt = digit_pat(w_sel_value, '0);
        end
      end

      S_WRITE: begin
        w_busy_nxt = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_gnt ? 2'b10 : 2'b01;
        end else begin
          w_cnt_nxt   = w_k;
          w_cs_nxt    = pio_sel(r_gnt, w_k);
          w_wr_n_nxt  = 1'b0;
          w_wdata_nxt = digit_pat(r_value, w_k);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_ack   <= 2'b00;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_cs    <= '0;
      r_wr_n  <= 1'b1;
      r_wdata <= 7'h7F;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_cs    <= w_cs_nxt;
      r_wr_n  <= w_wr_n_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_value <= w_value_nxt;
  end

  assign bus.ack           = r_ack;
  assign bus.done          = r_done;
  assign bus.busy          = r_busy;
  assign bus.pio_cs        = r_cs;
  assign bus.pio_write_n   = r_wr_n;
  assign bus.pio_address   = 2'b00;
  assign bus.pio_writedata = r_wdata;

endmodule

// File: tb/tb_hex_update_ctrl.sv
// Directed bench for hex_update_ctrl; expectations follow HEX_LZB_EN when defined.
module tb_hex_update_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

`ifdef HEX_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  hex_update_if #(.DIGITS(4)) bus ();

  hex_update_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ack"},   32'(bus.ack), 32'h0);
    chk({tag, ".done"},  32'(bus.done), 32'h0);
    chk({tag, ".busy"},  32'(bus.busy), 32'h0);
    chk({tag, ".cs"},    32'(bus.pio_cs), 32'h0);
    chk({tag, ".wr_n"},  32'(bus.pio_write_n), 32'h1);
    chk({tag, ".addr"},  32'(bus.pio_address), 32'h0);
    chk({tag, ".wdata"}, 32'(bus.pio_writedata), 32'h7F);
  endtask

  // Called in cycle 0 (request already driven); returns in cycle 6.
  task automatic xfer(input string tag, input int g,
                      input logic [6:0] p0, input logic [6:0] p1,
                      input logic [6:0] p2, input logic [6:0] p3);
    logic [6:0] p [4];
    logic [1:0] gb;
    logic [7:0] cs_exp;
    p  = '{p0, p1, p2, p3};
    gb = (g == 1) ? 2'b10 : 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      cs_exp = 8'h01 << (g * 4 + k);
      chk($sformatf("%s.ack%0d", tag, k),   32'(bus.ack), (k == 0) ? 32'(gb) : 32'h0);
      chk($sformatf("%s.busy%0d", tag, k),  32'(bus.busy), 32'h1);
      chk($sformatf("%s.cs%0d", tag, k),    32'(bus.pio_cs), 32'(cs_exp));
      chk($sformatf("%s.wr_n%0d", tag, k),  32'(bus.pio_write_n), 32'h0);
      chk($sformatf("%s.addr%0d", tag, k),  32'(bus.pio_address), 32'h0);
      chk($sformatf("%s.wdata%0d", tag, k), 32'(bus.pio_writedata), 32'(p[k]));
      chk($sformatf("%s.done%0d", tag, k),  32'(bus.done), 32'h0);
    end
    tick();
    chk({tag, ".done"},     32'(bus.done), 32'(gb));
    chk({tag, ".dn_busy"},  32'(bus.busy), 32'h1);
    chk({tag, ".dn_cs"},    32'(bus.pio_cs), 32'h0);
    chk({tag, ".dn_wr_n"},  32'(bus.pio_write_n), 32'h1);
    chk({tag, ".dn_wdata"}, 32'(bus.pio_writedata), 32'(p[3]));
    tick();
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, ".idle_done"}, 32'(bus.done), 32'h0);
    chk({tag, ".idle_ack"},  32'(bus.ack), 32'h0);
  endtask

  initial begin
    logic [1:0] seen_ad;
    logic [7:0] seen_cs;
    logic       seen_busy;
    logic       all_wr_n;
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.req    = 2'b00;
    bus.value0 = 16'h0000;
    bus.value1 = 16'h0000;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Idle for 10 cycles with no request
    seen_ad = 2'b00; seen_cs = 8'h00; seen_busy = 1'b0; all_wr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_ad   = seen_ad | bus.ack | bus.done;
      seen_cs   = seen_cs | bus.pio_cs;
      seen_busy = seen_busy | bus.busy;
      all_wr_n  = all_wr_n & bus.pio_write_n;
    end
    chk("idle.ack_done", 32'(seen_ad), 32'h0);
    chk("idle.cs",       32'(seen_cs), 32'h0);
    chk("idle.busy",     32'(seen_busy), 32'h0);
    chk("idle.wr_n",     32'(all_wr_n), 32'h1);
    chk("idle.wdata",    32'(bus.pio_writedata), 32'h7F);

    // Single request from requester 0
    bus.value0 = 16'h1250;
    bus.req    = 2'b01;
    xfer("r0", 0, 7'h40, 7'h12, 7'h24, 7'h79);
    bus.req = 2'b00;
    tick();

    // Both requesting from reset: strict alternation starting with requester 0
    reset = 1'b1;
    tick();
    chk_reset_vals("rst2");
    reset      = 1'b0;
    bus.value1 = 16'h0307;
    bus.req    = 2'b11;
    xfer("rr0", 0, 7'h40, 7'h12, 7'h24, 7'h79);
    xfer("rr1", 1, 7'h78, 7'h40, 7'h30, LZ);
    xfer("rr2", 0, 7'h40, 7'h12, 7'h24, 7'h79);
    bus.req = 2'b00;
    tick();

    // Value changes after grant are ignored
    bus.value1 = 16'hABCD;
    bus.req    = 2'b10;
    fork
      xfer("hold", 1, 7'h21, 7'h46, 7'h03, 7'h08);
      begin
        tick();
        tick();
        bus.value1 = 16'h0000;
        bus.req    = 2'b00;
      end
    join
    tick();

    // Reset in cycle 3 of a transfer aborts it
    bus.value0 = 16'h1250;
    bus.req    = 2'b01;
    tick();
    chk("abort.ack", 32'(bus.ack), 32'h1);
    tick();
    tick();
    chk("abort.wdata3", 32'(bus.pio_writedata), 32'h24);
    reset   = 1'b1;
    bus.req = 2'b00;
    tick();
    chk_reset_vals("abort");
    reset   = 1'b0;
    seen_ad = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_ad = seen_ad | bus.done | bus.ack;
    end
    chk("abort.no_done", 32'(seen_ad), 32'h0);
    bus.value1 = 16'h4096;
    bus.req    = 2'b10;
    xfer("post0", 1, 7'h02, 7'h10, 7'h40, 7'h19);
    xfer("post1", 1, 7'h02, 7'h10, 7'h40, 7'h19);
    bus.req = 2'b00;
    tick();

    // All-zero value: leading-zero blanking boundary
    bus.value0 = 16'h0000;
    bus.req    = 2'b01;
    xfer("zero", 0, 7'h40, LZ, LZ, LZ);
    bus.req = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
